// File: rtl/hmac_sha256.sv
// HMAC-SHA256 tag engine with a build-time key over a 72-byte message.
// One SHA-256 round per cycle; five compressions per tag.
module hmac_sha256 #(
    parameter logic [255:0] KEY = 256'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] req_data,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_counter,
    input  logic         req_val,
    output logic         req_rdy,
    output logic [255:0] hmac,
    output logic         hmac_val,
    input  logic         hmac_rdy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INNER1 = 3'd1;
    localparam logic [2:0] INNER2 = 3'd2;
    localparam logic [2:0] INNER3 = 3'd3;
    localparam logic [2:0] OUTER1 = 3'd4;
    localparam logic [2:0] OUTER2 = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bs0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bs1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    logic [2:0]   state;
    logic [6:0]   cnt;
    logic [511:0] data_q;
    logic [31:0]  addr_q;
    logic [31:0]  ctr_q;
    logic [255:0] inner_q;
    logic [255:0] hash_q;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  w [16];

    logic         first;
    logic [255:0] init;
    logic [511:0] blk;
    logic [5:0]   rnd;
    logic [31:0]  t1, t2, w_next;
    logic [255:0] sum;

    assign req_rdy  = (state == IDLE) && !rst;
    assign hmac_val = (state == DONE);

    // First block of each hash restarts from the IV, others chain from H.
    assign first = (state == INNER1) || (state == OUTER1);
    assign init  = first ? IV : hash_q;
    assign rnd   = cnt[5:0] - 6'd1;

    always_comb begin
        blk = '0;
        case (state)
            INNER1: blk = {KEY ^ {32{8'h36}}, {32{8'h36}}};
            INNER2: blk = data_q;
            INNER3: blk = {addr_q, ctr_q, 8'h80, 376'b0, 64'd1088};
            OUTER1: blk = {KEY ^ {32{8'h5c}}, {32{8'h5c}}};
            OUTER2: blk = {inner_q, 8'h80, 184'b0, 64'd768};
            default: blk = '0;
        endcase
    end

    always_comb begin
        t1 = h + bs1(e) + ((e & f) ^ (~e & g)) + K[rnd] + w[0];
        t2 = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_next = ss1(w[14]) + w[9] + ss0(w[1]) + w[0];
    end

    assign sum = {
        hash_q[255:224] + a, hash_q[223:192] + b,
        hash_q[191:160] + c, hash_q[159:128] + d,
        hash_q[127:96]  + e, hash_q[95:64]   + f,
        hash_q[63:32]   + g, hash_q[31:0]    + h
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            ctr_q   <= '0;
            inner_q <= '0;
            hash_q  <= '0;
            hmac    <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val && req_rdy) begin
                        data_q <= req_data;
                        addr_q <= req_addr;
                        ctr_q  <= req_counter;
                        cnt    <= '0;
                        state  <= INNER1;
                    end
                end
                DONE: begin
                    if (hmac_rdy) state <= IDLE;
                end
                default: begin
                    if (cnt == 7'd0) begin
                        if (first) hash_q <= IV;
                        {a, b, c, d, e, f, g, h} <= init;
                        for (int i = 0; i < 16; i++)
                            w[i] <= blk[511 - 32*i -: 32];
                        cnt <= 7'd1;
                    end else if (cnt <= 7'd64) begin
                        h <= g;
                        g <= f;
                        f <= e;
                        e <= d + t1;
                        d <= c;
                        c <= b;
                        b <= a;
                        a <= t1 + t2;
                        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                        w[15] <= w_next;
                        cnt <= cnt + 7'd1;
                    end else begin
                        hash_q <= sum;
                        cnt    <= '0;
                        if (state == INNER3) inner_q <= sum;
                        if (state == OUTER2) begin
                            hmac  <= sum;
                            state <= DONE;
                        end else begin
                            state <= state + 3'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hmac_sha256.sv
// Directed bench for hmac_sha256 against a byte-level software HMAC model.
// Tags come from a generic SHA-256 over padded byte queues.
module tb_hmac_sha256;
    localparam logic [255:0] KEY = 256'h0;

    typedef logic [7:0] bq_t [$];

    localparam logic [31:0] KC [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] req_data;
    logic [31:0]  req_addr;
    logic [31:0]  req_counter;
    logic         req_val;
    logic         req_rdy;
    logic [255:0] hmac;
    logic         hmac_val;
    logic         hmac_rdy;

    int checks = 0;
    int passed = 0;

    hmac_sha256 #(.KEY(KEY)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (req_data),
        .req_addr    (req_addr),
        .req_counter (req_counter),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .hmac        (hmac),
        .hmac_val    (hmac_val),
        .hmac_rdy    (hmac_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256(input bq_t msg);
        bq_t m;
        logic [63:0] bitlen;
        logic [31:0] hh [8];
        logic [31:0] w [64];
        logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2, s0, s1;
        int base;
        m = msg;
        bitlen = 64'(m.size()) * 64'd8;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(bitlen[8*i +: 8]);
        hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int bk = 0; bk < m.size() / 64; bk++) begin
            base = 64 * bk;
            for (int t = 0; t < 16; t++)
                w[t] = {m[base+4*t], m[base+4*t+1], m[base+4*t+2], m[base+4*t+3]};
            for (int t = 16; t < 64; t++) begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            va = hh[0]; vb = hh[1]; vc = hh[2]; vd = hh[3];
            ve = hh[4]; vf = hh[5]; vg = hh[6]; vh = hh[7];
            for (int t = 0; t < 64; t++) begin
                t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25))
                     + ((ve & vf) ^ (~ve & vg)) + KC[t] + w[t];
                t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22))
                     + ((va & vb) ^ (va & vc) ^ (vb & vc));
                vh = vg; vg = vf; vf = ve; ve = vd + t1;
                vd = vc; vc = vb; vb = va; va = t1 + t2;
            end
            hh[0] += va; hh[1] += vb; hh[2] += vc; hh[3] += vd;
            hh[4] += ve; hh[5] += vf; hh[6] += vg; hh[7] += vh;
        end
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    endfunction

    function automatic logic [255:0] hmac_model(input logic [511:0] d,
                                                input logic [31:0] ad,
                                                input logic [31:0] ct);
        bq_t q;
        logic [575:0] msg;
        logic [511:0] kb;
        logic [255:0] ih;
        msg = {d, ad, ct};
        kb = {KEY, 256'h0};
        for (int i = 0; i < 64; i++) q.push_back(kb[511-8*i -: 8] ^ 8'h36);
        for (int i = 0; i < 72; i++) q.push_back(msg[575-8*i -: 8]);
        ih = sha256(q);
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back(kb[511-8*i -: 8] ^ 8'h5c);
        for (int i = 0; i < 32; i++) q.push_back(ih[255-8*i -: 8]);
        return sha256(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise req_val and return right after the accepting edge.
    task automatic send(input logic [511:0] d, input logic [31:0] ad,
                        input logic [31:0] ct, output bit ok);
        bit r;
        req_data = d;
        req_addr = ad;
        req_counter = ct;
        req_val = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            r = req_rdy;
            tick();
            if (r) ok = 1'b1;
        end
    endtask

    task automatic wait_tag(output int n);
        n = 0;
        while (!hmac_val && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_model();
        bq_t q;
        logic [255:0] got;
        q = '{8'h61, 8'h62, 8'h63};
        got = sha256(q);
        checks++;
        if (got !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad)
            $display("FAIL model_abc got=%h", got);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_val = 1'b0;
        hmac_rdy = 1'b0;
        req_data = '0;
        req_addr = '0;
        req_counter = '0;
        tick();
        tick();
        checks++;
        if (req_rdy !== 1'b0) $display("FAIL reset_rdy_in_rst got=%b want=0", req_rdy);
        else passed++;
        checks++;
        if (hmac_val !== 1'b0) $display("FAIL reset_val got=%b want=0", hmac_val);
        else passed++;
        checks++;
        if (hmac !== 256'h0) $display("FAIL reset_hmac got=%h want=0", hmac);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1) $display("FAIL reset_rdy_after got=%b want=1", req_rdy);
        else passed++;
    endtask

    task automatic test_zero();
        logic [255:0] exp;
        bit ok;
        int n;
        exp = hmac_model('0, '0, '0);
        send('0, '0, '0, ok);
        checks++;
        if (!ok) $display("FAIL zero_accept got=none want=accept");
        else passed++;
        checks++;
        if (req_rdy !== 1'b0) $display("FAIL zero_rdy_busy got=%b want=0", req_rdy);
        else passed++;
        req_val = 1'b0;
        wait_tag(n);
        checks++;
        if (n !== 330) $display("FAIL zero_latency got=%0d want=330", n);
        else passed++;
        checks++;
        if (hmac !== exp) $display("FAIL zero_tag got=%h want=%h", hmac, exp);
        else passed++;
        hmac_rdy = 1'b1;
        tick();
        hmac_rdy = 1'b0;
        checks++;
        if (hmac_val !== 1'b0 || req_rdy !== 1'b1)
            $display("FAIL zero_xfer got val=%b rdy=%b want val=0 rdy=1", hmac_val, req_rdy);
        else passed++;
    endtask

    task automatic test_sequential();
        logic [511:0] dv [3];
        logic [31:0]  av [3];
        logic [31:0]  cv [3];
        logic [255:0] exp;
        bit ok;
        int n, bad;
        dv[0] = 512'hdeadbeef;   av[0] = 32'hbeefdead; cv[0] = 32'haaaaaaaa;
        dv[1] = 512'h11111111;   av[1] = 32'h22222222; cv[1] = 32'h33333333;
        dv[2] = {16{32'h01234567}}; av[2] = 32'habcdef01; cv[2] = 32'h23456789;
        for (int k = 0; k < 3; k++) begin
            exp = hmac_model(dv[k], av[k], cv[k]);
            send(dv[k], av[k], cv[k], ok);
            tick();
            tick();
            checks++;
            if (!ok || req_rdy !== 1'b0)
                $display("FAIL seq%0d_accept got ok=%b rdy=%b want ok=1 rdy=0", k, ok, req_rdy);
            else passed++;
            req_val = 1'b0;
            wait_tag(n);
            checks++;
            if (n + 2 !== 330) $display("FAIL seq%0d_latency got=%0d want=330", k, n + 2);
            else passed++;
            checks++;
            if (hmac !== exp) $display("FAIL seq%0d_tag got=%h want=%h", k, hmac, exp);
            else passed++;
            hmac_rdy = 1'b1;
            tick();
            hmac_rdy = 1'b0;
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                if (hmac_val !== 1'b0 || req_rdy !== 1'b1 || hmac !== exp) bad++;
                tick();
            end
            checks++;
            if (bad !== 0) $display("FAIL seq%0d_idle_hold got=%0d bad cycles want=0", k, bad);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] exp;
        bit ok;
        int n, bad;
        exp = hmac_model(512'h5a5a, 32'h1, 32'h2);
        send(512'h5a5a, 32'h1, 32'h2, ok);
        req_val = 1'b0;
        wait_tag(n);
        checks++;
        if (!ok || n !== 330) $display("FAIL bp_latency got=%0d want=330", n);
        else passed++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (hmac_val !== 1'b1 || hmac !== exp || req_rdy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL bp_hold got=%0d bad cycles want=0", bad);
        else passed++;
        hmac_rdy = 1'b1;
        tick();
        hmac_rdy = 1'b0;
        checks++;
        if (hmac_val !== 1'b0 || req_rdy !== 1'b1 || hmac !== exp)
            $display("FAIL bp_xfer got val=%b rdy=%b want val=0 rdy=1", hmac_val, req_rdy);
        else passed++;
    endtask

    task automatic test_early_rdy();
        logic [255:0] exp;
        bit ok;
        int n;
        exp = hmac_model(512'hc0ffee, 32'hfeedface, 32'h7);
        hmac_rdy = 1'b1;
        send(512'hc0ffee, 32'hfeedface, 32'h7, ok);
        req_val = 1'b0;
        wait_tag(n);
        checks++;
        if (!ok || n !== 330) $display("FAIL early_latency got=%0d want=330", n);
        else passed++;
        checks++;
        if (hmac !== exp) $display("FAIL early_tag got=%h want=%h", hmac, exp);
        else passed++;
        tick();
        checks++;
        if (hmac_val !== 1'b0 || req_rdy !== 1'b1)
            $display("FAIL early_one_cycle got val=%b rdy=%b want val=0 rdy=1", hmac_val, req_rdy);
        else passed++;
        hmac_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [255:0] ea, eb;
        bit ok;
        int n;
        ea = hmac_model(512'h1, 32'h2, 32'h3);
        eb = hmac_model(512'h4, 32'h5, 32'h6);
        hmac_rdy = 1'b1;
        send(512'h1, 32'h2, 32'h3, ok);
        req_data = 512'h4;
        req_addr = 32'h5;
        req_counter = 32'h6;
        wait_tag(n);
        checks++;
        if (!ok || n !== 330 || hmac !== ea)
            $display("FAIL b2b_first got n=%0d tag=%h want n=330 tag=%h", n, hmac, ea);
        else passed++;
        tick();
        checks++;
        if (req_rdy !== 1'b1) $display("FAIL b2b_idle got=%b want=1", req_rdy);
        else passed++;
        tick();
        req_val = 1'b0;
        checks++;
        if (req_rdy !== 1'b0) $display("FAIL b2b_reaccept got=%b want=0", req_rdy);
        else passed++;
        wait_tag(n);
        checks++;
        if (n !== 330 || hmac !== eb)
            $display("FAIL b2b_second got n=%0d tag=%h want n=330 tag=%h", n, hmac, eb);
        else passed++;
        tick();
        hmac_rdy = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [255:0] exp;
        bit ok;
        int n, seen;
        exp = hmac_model('0, '0, '0);
        send(512'hbad, 32'hbad, 32'hbad, ok);
        req_val = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 1'b0) $display("FAIL midrst_rdy_in_rst got=%b want=0", req_rdy);
        else passed++;
        tick();
        checks++;
        if (hmac_val !== 1'b0 || hmac !== 256'h0)
            $display("FAIL midrst_outputs got val=%b hmac=%h want 0", hmac_val, hmac);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1) $display("FAIL midrst_rdy got=%b want=1", req_rdy);
        else passed++;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (hmac_val !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL midrst_discard got=%0d valid cycles want=0", seen);
        else passed++;
        send('0, '0, '0, ok);
        req_val = 1'b0;
        wait_tag(n);
        checks++;
        if (!ok || n !== 330 || hmac !== exp)
            $display("FAIL midrst_after got n=%0d tag=%h want n=330 tag=%h", n, hmac, exp);
        else passed++;
        hmac_rdy = 1'b1;
        tick();
        hmac_rdy = 1'b0;
    endtask

    initial begin
        test_model();
        test_reset();
        test_zero();
        test_sequential();
        test_backpressure();
        test_early_rdy();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/hmac_sha256.md
Name: hmac_sha256

Overview:
- Computes HMAC-SHA256, with a fixed build-time key, over a 72-byte message built from a 512-bit data word, a 32-bit address and a 32-bit counter.
- Used as a memory-authentication tag generator: one request in, one 256-bit tag out.
- Valid/ready handshake on both sides; one request in flight at a time.

Parameters:
- KEY, 256'h0, HMAC key. Zero-extended on the right to a 64-byte block (K || 32 zero bytes), as in RFC 2104.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_data  in  512  message data.
- req_addr  in  32  message address.
- req_counter  in  32  message counter/version.
- req_val  in  1  request valid.
- req_rdy  out  1  block idle and able to accept a request.
- hmac  out  256  resulting tag, SHA-256 big-endian (H0 in bits 255:224).
- hmac_val  out  1  tag valid.
- hmac_rdy  in  1  consumer ready for the tag.

Behaviour:
- Message M is 72 bytes, big-endian: req_data[511:0] || req_addr[31:0] || req_counter[31:0]. The byte at req_data[511:504] comes first.
- Tag = SHA256((K^opad) || SHA256((K^ipad) || M)), with ipad = 0x36 repeated and opad = 0x5c repeated.
- Inner hash is 3 blocks:
  - (1) K^ipad.
  - (2) req_data.
  - (3) addr || counter || 0x80 || 47 zero bytes || 64-bit length 1088 (0x440).
- Outer hash is 2 blocks:
  - (1) K^opad.
  - (2) inner digest || 0x80 || 23 zero bytes || 64-bit length 768 (0x300).
- Datapath: a single SHA-256 compression core doing one round per cycle.
  - Each block takes 66 cycles: 1 load cycle (W init / state copy), 64 rounds, 1 cycle for the feed-forward add into H.
  - Hash state is re-initialised to the standard SHA-256 IV before inner block 1 and before outer block 1.
- FSM states: IDLE -> INNER1 -> INNER2 -> INNER3 -> OUTER1 -> OUTER2 -> DONE -> IDLE.
- IDLE:
  - req_rdy=1.
  - When req_val && req_rdy at a rising edge, latch data/addr/counter, go to INNER1, and drive req_rdy=0 from the next cycle.
- Latency: hmac_val rises exactly 330 cycles after the accept edge. Inputs may change freely after accept.
- DONE:
  - hmac_val=1, hmac holds the tag, stable until the transfer.
  - Transfer occurs on hmac_val && hmac_rdy at a rising edge; go to IDLE, hmac_val=0 and req_rdy=1 from the next cycle.
  - hmac_rdy may be asserted early (before hmac_val); the transfer then happens on the first cycle hmac_val is high.
- req_val held high across and after the accept is not a new request until req_rdy is high again. A request still asserted when returning to IDLE is accepted (back-to-back).
- Only one request is in flight; no queueing.
- hmac retains its last value after the transfer until the next tag is written.
- Reset, in any state including mid-computation: next cycle state=IDLE, req_rdy=1, hmac_val=0, hmac=0, and all internal hash and working registers cleared. An in-flight request is discarded with no output.
- During reset assertion req_rdy=0.
- SHA-256 arithmetic is modulo 2^32 with standard K constants and Σ/σ functions. Message schedule uses a 16-word sliding window.

Test Plan:
- Golden model: software HMAC-SHA256 (e.g. Python hmac) over the 72-byte M above, with the default KEY. Compare hmac with it for every case.
- Reset then data=0, addr=0, counter=0:
  - req_rdy=1 after reset.
  - Exactly one accept.
  - hmac_val 330 cycles later.
  - hmac equals the golden tag for 72 zero bytes.
- Sequential requests (data=0xdeadbeef, addr=0xbeefdead, ctr=0xaaaaaaaa), then (0x11111111, 0x22222222, 0x33333333), then data = 0x01234567 repeated 16 times with addr=0xabcdef01, ctr=0x23456789:
  - Each tag matches golden.
  - req_val held 2 extra cycles after accept causes no second computation.
- Backpressure: hold hmac_rdy=0 for 50 cycles after hmac_val -> hmac_val stays 1, hmac stable, req_rdy stays 0. Raise hmac_rdy -> one transfer, then req_rdy=1.
- hmac_rdy high before and throughout the request -> transfer on the first hmac_val cycle; hmac_val is high exactly one cycle.
- Assert rst at cycle 100 of a computation -> outputs return to reset values. A following request (data=0) produces the correct golden tag.
